// File: rtl/display_sched.sv
`default_nettype none
// ============================================================================
// Module      : display_sched
// Description : Round-robin arbiter between two 8-bit sources feeding a
//               three-digit 7-segment display.  A granted value is shown
//               either as hex (one cycle) or as decimal via an 8-step
//               shift-and-add-3 conversion.  The digits only change when a
//               conversion completes, so partial results are never shown.
// Revision    : 1.0 - initial release
// ============================================================================
module display_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [7:0] data_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  input  logic       mode,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [3:0] digit_un,
  output logic [3:0] digit_dez,
  output logic [3:0] digit_cen,
  output logic       src,
  output logic       busy,
  output logic       upd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        ptr;       // 0: A has priority on a tie, 1: B has priority
  logic        win;       // source captured for the conversion in flight
  logic        is_dec;    // captured display mode
  logic [7:0]  value;     // captured source value
  logic [7:0]  shreg;     // binary bits still to be shifted into the BCD scratch
  logic [11:0] bcd;       // BCD scratch {hundreds, tens, units}
  logic [2:0]  cnt;       // SHIFT iteration counter
  logic        pick_a;
  logic        pick_b;
  logic [3:0]  adj_un;
  logic [3:0]  adj_dez;
  logic [3:0]  adj_cen;
  logic [11:0] adj_all;
  logic [11:0] bcd_next;

  // Round-robin pick: a lone requester wins, a tie goes to the pointer's source
  always_comb begin
    pick_a = req_a & (~req_b | ~ptr);
    pick_b = req_b & ~pick_a;
  end

  // One double-dabble step: add 3 to each nibble >= 5, then shift in the next bit
  always_comb begin
    adj_un   = (bcd[3:0]  >= 4'd5) ? bcd[3:0]  + 4'd3 : bcd[3:0];
    adj_dez  = (bcd[7:4]  >= 4'd5) ? bcd[7:4]  + 4'd3 : bcd[7:4];
    adj_cen  = (bcd[11:8] >= 4'd5) ? bcd[11:8] + 4'd3 : bcd[11:8];
    adj_all  = {adj_cen, adj_dez, adj_un};
    bcd_next = (adj_all << 1) | {11'd0, shreg[7]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req_a | req_b) state_next = S_CONV;
      S_CONV:  state_next = is_dec ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt == 3'd7) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; grants only in IDLE and never while in reset
  always_comb begin
    gnt_a = (state == S_IDLE) & ~reset & pick_a;
    gnt_b = (state == S_IDLE) & ~reset & pick_b;
    busy  = (state != S_IDLE);
    upd   = (state == S_DONE);
  end

  // Capture on grant, run the conversion, and publish digits only at completion
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= 1'b0;
      win       <= 1'b0;
      is_dec    <= 1'b0;
      value     <= 8'd0;
      shreg     <= 8'd0;
      bcd       <= 12'd0;
      cnt       <= 3'd0;
      digit_un  <= 4'd0;
      digit_dez <= 4'd0;
      digit_cen <= 4'd0;
      src       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_a | gnt_b) begin
            win    <= gnt_b;
            value  <= gnt_b ? data_b : data_a;
            is_dec <= mode;
            ptr    <= gnt_a;   // next tie goes to the source that just lost
          end
        end
        S_CONV: begin
          if (is_dec) begin
            bcd   <= 12'd0;
            shreg <= value;
            cnt   <= 3'd0;
          end else begin
            digit_cen <= 4'd0;
            digit_dez <= value[7:4];
            digit_un  <= value[3:0];
            src       <= win;
          end
        end
        S_SHIFT: begin
          bcd   <= bcd_next;
          shreg <= shreg << 1;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            digit_cen <= bcd_next[11:8];
            digit_dez <= bcd_next[7:4];
            digit_un  <= bcd_next[3:0];
            src       <= win;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_sched
// Description : Directed, table-driven self-checking bench for display_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b, mode;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b, src, busy, upd;
  logic [3:0] digit_un, digit_dez, digit_cen;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  display_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .mode      (mode),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .digit_un  (digit_un),
    .digit_dez (digit_dez),
    .digit_cen (digit_cen),
    .src       (src),
    .busy      (busy),
    .upd       (upd)
  );

  typedef struct {
    logic       ra;
    logic       rb;
    logic [7:0] da;
    logic [7:0] db;
    logic       md;
    logic       ega;
    logic       egb;
    logic       es;
    logic [3:0] ecen;
    logic [3:0] edez;
    logic [3:0] eun;
    int         elat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Apply one transaction from IDLE and check grant, latency, hold and result
  task automatic run_vec(input vec_t v);
    logic [11:0] prev;
    logic        prev_src;
    int          lat;
    logic        stable;
    req_a  = v.ra;
    req_b  = v.rb;
    data_a = v.da;
    data_b = v.db;
    mode   = v.md;
    #1;
    check("grant", {14'd0, gnt_a, gnt_b}, {14'd0, v.ega, v.egb});
    prev     = {digit_cen, digit_dez, digit_un};
    prev_src = src;
    tick;
    req_a  = 1'b0;
    req_b  = 1'b0;
    lat    = 0;
    stable = 1'b1;
    while (!upd && lat < 20) begin
      if ({digit_cen, digit_dez, digit_un} !== prev || src !== prev_src) stable = 1'b0;
      tick;
      lat++;
    end
    check("latency", 16'(lat), 16'(v.elat));
    check("hold_during_conv", {15'd0, stable}, 16'd1);
    check("digits", {4'd0, digit_cen, digit_dez, digit_un}, {4'd0, v.ecen, v.edez, v.eun});
    check("src", {15'd0, src}, {15'd0, v.es});
    tick;
    check("idle_after_done", {14'd0, busy, upd}, 16'd0);
  endtask

  initial begin
    logic ok;
    int   n;

    vecs[0] = '{1'b1, 1'b0, 8'hAB, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'hA, 4'hB, 1};
    vecs[1] = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 4'h5, 4'h5, 9};
    vecs[2] = '{1'b1, 1'b0, 8'h64, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 9};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 9};
    vecs[4] = '{1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h3, 4'h4, 1};
    vecs[5] = '{1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h1, 4'h2, 1};
    vecs[6] = '{1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h5, 4'h2, 9};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 8'hC8, 1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 4'h0, 4'h0, 9};
    vecs[8] = '{1'b1, 1'b1, 8'h63, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h9, 4'h9, 9};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'hF, 1};

    // Reset for two cycles with a request pending: reset wins
    reset  = 1'b1;
    req_a  = 1'b1;
    req_b  = 1'b0;
    data_a = 8'h55;
    data_b = 8'h00;
    mode   = 1'b0;
    tick;
    tick;
    check("reset_digits", {4'd0, digit_cen, digit_dez, digit_un}, 16'd0);
    check("reset_flags", {12'd0, src, busy, upd, 1'b0}, 16'd0);
    check("reset_grants", {14'd0, gnt_a, gnt_b}, 16'd0);
    req_a = 1'b0;
    reset = 1'b0;
    tick;
    check("idle_after_reset", {14'd0, busy, upd}, 16'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Both held in hex mode from reset: A, B, A, B with one update per 3 cycles
    reset = 1'b1;
    tick;
    reset  = 1'b0;
    req_a  = 1'b1;
    req_b  = 1'b1;
    data_a = 8'h12;
    data_b = 8'h34;
    mode   = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rr_grant", {14'd0, gnt_a, gnt_b}, (k % 2 == 0) ? 16'b10 : 16'b01);
      tick;
      check("rr_no_grant_busy", {13'd0, gnt_a, gnt_b, busy}, 16'b001);
      tick;
      check("rr_upd", {15'd0, upd}, 16'd1);
      check("rr_digits", {3'd0, src, digit_cen, digit_dez, digit_un},
            (k % 2 == 0) ? 16'h0012 : 16'h1034);
      tick;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    #1;

    // Reset during the 4th SHIFT cycle of a decimal conversion of 200
    data_a = 8'd200;
    mode   = 1'b1;
    req_a  = 1'b1;
    #1;
    check("abort_grant", {14'd0, gnt_a, gnt_b}, 16'b10);
    tick;
    req_a = 1'b0;
    for (int k = 0; k < 4; k++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_state", {4'd0, digit_cen, digit_dez, digit_un}, 16'd0);
    check("abort_idle", {13'd0, busy, upd, src}, 16'd0);
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (upd !== 1'b0) ok = 1'b0;
      tick;
    end
    check("abort_no_upd", {15'd0, ok}, 16'd1);
    run_vec('{1'b1, 1'b0, 8'd200, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 4'h0, 4'h0, 9});

    // req_b arrives mid-conversion of A and is held until the first IDLE cycle
    data_a = 8'd50;
    mode   = 1'b1;
    req_a  = 1'b1;
    #1;
    tick;
    req_a  = 1'b0;
    tick;
    req_b  = 1'b1;
    data_b = 8'h34;
    mode   = 1'b0;
    #1;
    ok = 1'b1;
    n  = 0;
    while (!upd && n < 20) begin
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0) ok = 1'b0;
      if ({digit_cen, digit_dez, digit_un} !== 12'h200) ok = 1'b0;
      tick;
      n++;
    end
    check("held_no_grant_while_busy", {15'd0, ok}, 16'd1);
    check("held_a_result", {3'd0, src, digit_cen, digit_dez, digit_un}, 16'h0050);
    check("held_no_grant_in_done", {14'd0, gnt_a, gnt_b}, 16'd0);
    tick;
    check("held_gnt_b_first_idle", {13'd0, busy, gnt_a, gnt_b}, 16'b001);
    tick;
    req_b = 1'b0;
    tick;
    check("held_b_result", {2'd0, upd, src, digit_cen, digit_dez, digit_un}, 16'h3034);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
